// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one DMA engine among NUM_CH requesters.
// Each channel holds at most one descriptor. The scheduler issues one descriptor at a time and reports its completion.
module dma_chan_sched #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req_valid,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic [NUM_CH*32-1:0] req_src,
    input  logic [NUM_CH*32-1:0] req_dst,
    input  logic [NUM_CH*16-1:0] req_len,
    input  logic [NUM_CH-1:0]    req_burst,
    output logic [31:0]          dma_src_addr,
    output logic [31:0]          dma_dst_addr,
    output logic [15:0]          dma_length,
    output logic [2:0]           dma_channel,
    output logic                 dma_burst,
    output logic                 dma_start,
    input  logic                 dma_done,
    input  logic [3:0]           dma_status,
    output logic                 cpl_valid,
    output logic [2:0]           cpl_channel,
    output logic [3:0]           cpl_status,
    output logic                 cpl_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;

    state_t              r_state, w_next;
    logic [NUM_CH-1:0]   r_pending;
    logic [31:0]         r_src [NUM_CH];
    logic [31:0]         r_dst [NUM_CH];
    logic [15:0]         r_len [NUM_CH];
    logic [NUM_CH-1:0]   r_burst;
    logic [2:0]          r_rr_ptr;
    logic [2:0]          r_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_dma_src, r_dma_dst;
    logic [15:0]         r_dma_len;
    logic [2:0]          r_dma_ch;
    logic                r_dma_burst;
    logic [2:0]          r_cpl_ch;
    logic [3:0]          r_cpl_status;
    logic                r_cpl_to;

    logic                w_any;
    logic [2:0]          w_win;
    logic [3:0]          w_dist, w_best;
    logic [31:0]         w_sel_src, w_sel_dst;
    logic [15:0]         w_sel_len;
    logic                w_sel_burst;
    logic                w_cnt_hit;
    logic                w_start, w_cpl;

    assign req_ready = ~r_pending;
    assign w_cnt_hit = (r_cnt == CNT_LAST);

    // Winner is the pending slot with the smallest rotated distance from rr_ptr.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_best = 4'hF;
        w_dist = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) >= r_rr_ptr) w_dist = 4'(i) - {1'b0, r_rr_ptr};
            else                   w_dist = 4'(i) + 4'(NUM_CH) - {1'b0, r_rr_ptr};
            if (r_pending[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = 3'(i);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_src   = '0;
        w_sel_dst   = '0;
        w_sel_len   = '0;
        w_sel_burst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == 3'(i)) begin
                w_sel_src   = r_src[i];
                w_sel_dst   = r_dst[i];
                w_sel_len   = r_len[i];
                w_sel_burst = r_burst[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((r_state == S_CPL) && (r_grant == 3'(i))) r_pending[i] <= 1'b0;
                else if (req_valid[i] && !r_pending[i])        r_pending[i] <= 1'b1;
            end
        end
    end

    // Slot contents are only meaningful while pending is set, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_valid[i] && !r_pending[i]) begin
                r_src[i]   <= req_src[32*i +: 32];
                r_dst[i]   <= req_dst[32*i +: 32];
                r_len[i]   <= req_len[16*i +: 16];
                r_burst[i] <= req_burst[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = (w_sel_len == 16'd0) ? S_CPL : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (dma_done || w_cnt_hit) w_next = S_CPL;
            S_CPL:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = (r_state == S_ISSUE);
        w_cpl   = (r_state == S_CPL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_dma_src    <= '0;
            r_dma_dst    <= '0;
            r_dma_len    <= '0;
            r_dma_ch     <= '0;
            r_dma_burst  <= 1'b0;
            r_cpl_ch     <= '0;
            r_cpl_status <= '0;
            r_cpl_to     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_dma_src    <= w_sel_src;
                        r_dma_dst    <= w_sel_dst;
                        r_dma_len    <= w_sel_len;
                        r_dma_ch     <= w_win;
                        r_dma_burst  <= w_sel_burst;
                        r_grant      <= w_win;
                        r_cpl_ch     <= w_win;
                        r_cpl_status <= 4'h0;
                        r_cpl_to     <= 1'b0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dma_done) begin
                        r_cpl_status <= dma_status;
                    end else if (w_cnt_hit) begin
                        r_cpl_status <= 4'hF;
                        r_cpl_to     <= 1'b1;
                    end
                end
                S_CPL: r_rr_ptr <= (r_grant == 3'(NUM_CH - 1)) ? 3'd0 : r_grant + 3'd1;
                default: ;
            endcase
        end
    end

    assign dma_src_addr = r_dma_src;
    assign dma_dst_addr = r_dma_dst;
    assign dma_length   = r_dma_len;
    assign dma_channel  = r_dma_ch;
    assign dma_burst    = r_dma_burst;
    assign dma_start    = w_start;
    assign cpl_valid    = w_cpl;
    assign cpl_channel  = r_cpl_ch;
    assign cpl_status   = r_cpl_status;
    assign cpl_timeout  = r_cpl_to;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Scoreboard bench for dma_chan_sched: stimulus queues expected starts/completions, a negedge monitor checks them.
// Cycle stamps are the posedge count, so an accept at edge A shows dma_start at stamp A+1.
module tb_dma_chan_sched;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    req_valid, req_ready, req_burst;
    logic [NUM_CH*32-1:0] req_src, req_dst;
    logic [NUM_CH*16-1:0] req_len;
    logic [31:0]          dma_src_addr, dma_dst_addr;
    logic [15:0]          dma_length;
    logic [2:0]           dma_channel, cpl_channel;
    logic                 dma_burst, dma_start, dma_done, cpl_valid, cpl_timeout;
    logic [3:0]           dma_status, cpl_status;

    dma_chan_sched #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .req_burst(req_burst),
        .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr), .dma_length(dma_length),
        .dma_channel(dma_channel), .dma_burst(dma_burst), .dma_start(dma_start),
        .dma_done(dma_done), .dma_status(dma_status),
        .cpl_valid(cpl_valid), .cpl_channel(cpl_channel), .cpl_status(cpl_status),
        .cpl_timeout(cpl_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        burst;
    } start_t;

    typedef struct packed {
        logic [2:0] ch;
        logic [3:0] status;
        logic       to;
    } cpl_t;

    start_t exp_start[$];
    cpl_t   exp_cpl[$];
    start_t ms;
    cpl_t   mc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0, n_cpl = 0;
    int last_start_cyc = 0, last_cpl_cyc = 0;
    int acc_cyc = 0;
    int c0;
    logic       auto_done = 1'b0;
    int         done_gap  = 1;
    logic [3:0] resp_status = 4'h0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every start/completion the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        if (dma_start) begin
            n_start++;
            last_start_cyc = cyc;
            if (exp_start.size() == 0) chk("unexpected_start", 1, 0);
            else begin
                ms = exp_start.pop_front();
                chk("start_ch", dma_channel, ms.ch);
                chk("start_src", dma_src_addr, ms.src);
                chk("start_dst", dma_dst_addr, ms.dst);
                chk("start_len", dma_length, ms.len);
                chk("start_burst", dma_burst, ms.burst);
            end
        end
        if (cpl_valid) begin
            n_cpl++;
            last_cpl_cyc = cyc;
            if (exp_cpl.size() == 0) chk("unexpected_cpl", 1, 0);
            else begin
                mc = exp_cpl.pop_front();
                chk("cpl_ch", cpl_channel, mc.ch);
                chk("cpl_status", cpl_status, mc.status);
                chk("cpl_timeout", cpl_timeout, mc.to);
            end
        end
    end

    // Engine model: answers each start with a one-cycle done done_gap cycles later.
    always @(negedge clk) begin
        if (dma_start && auto_done) begin
            repeat (done_gap) @(negedge clk);
            dma_done   = 1'b1;
            dma_status = resp_status;
            @(negedge clk);
            dma_done   = 1'b0;
        end
    end

    task automatic set_ch(input int ch, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic b);
        req_src[ch*32 +: 32] = s;
        req_dst[ch*16*2 +: 32] = d;
        req_len[ch*16 +: 16] = l;
        req_burst[ch] = b;
    endtask

    task automatic exp_s(input int ch, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] l, input logic b);
        start_t t;
        t.ch = 3'(ch); t.src = s; t.dst = d; t.len = l; t.burst = b;
        exp_start.push_back(t);
    endtask

    task automatic exp_c(input int ch, input logic [3:0] st, input logic to);
        cpl_t t;
        t.ch = 3'(ch); t.status = st; t.to = to;
        exp_cpl.push_back(t);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        @(negedge clk);
        req_valid = mask;
        @(negedge clk);
        req_valid = '0;
        acc_cyc = cyc;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((exp_start.size() != 0 || exp_cpl.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, (n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_src = '0; req_dst = '0; req_len = '0;
        req_burst = '0; dma_done = 1'b0; dma_status = '0;
        #12;
        chk("rst_ready", req_ready, 4'hF);
        chk("rst_src", dma_src_addr, 0);
        chk("rst_ctrl", {dma_length, dma_channel, dma_burst, dma_start, cpl_valid,
                         cpl_channel, cpl_status, cpl_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on ch2, done three cycles after start.
        auto_done = 1'b1; done_gap = 3; resp_status = 4'h1;
        set_ch(2, 32'h1000, 32'h2000, 16'd64, 1'b1);
        exp_s(2, 32'h1000, 32'h2000, 16'd64, 1'b1);
        exp_c(2, 4'h1, 1'b0);
        pulse(4'b0100);
        chk("t1_ready_blocked", req_ready[2], 0);
        drain("t1_drain", 40);
        chk("t1_start_lat", last_start_cyc - acc_cyc, 1);
        chk("t1_cpl_lat", last_cpl_cyc - last_start_cyc, 4);
        chk("t1_ready_in_cpl", req_ready[2], 0);
        @(negedge clk);
        chk("t1_ready_after", req_ready, 4'hF);

        // ch3 alone brings rr_ptr back to 0.
        done_gap = 2; resp_status = 4'h7;
        set_ch(3, 32'h3300, 32'h3400, 16'd12, 1'b0);
        exp_s(3, 32'h3300, 32'h3400, 16'd12, 1'b0);
        exp_c(3, 4'h7, 1'b0);
        pulse(4'b1000);
        drain("t1b_drain", 40);

        // All four at once, twice: order 0,1,2,3 each round.
        done_gap = 1;
        for (int r = 0; r < 2; r++) begin
            resp_status = (r == 0) ? 4'h2 : 4'h5;
            for (int c = 0; c < NUM_CH; c++) begin
                set_ch(c, 32'hA000 + 32'(c * 16 + r), 32'hB000 + 32'(c * 16 + r),
                       16'(c + 4 * r + 1), 1'(c));
                exp_s(c, 32'hA000 + 32'(c * 16 + r), 32'hB000 + 32'(c * 16 + r),
                      16'(c + 4 * r + 1), 1'(c));
                exp_c(c, resp_status, 1'b0);
            end
            pulse(4'b1111);
            drain("t2_drain", 120);
        end

        // ch1 alone sets rr_ptr=2; then ch1+ch3 together -> ch3 first.
        resp_status = 4'h3;
        set_ch(1, 32'h0111, 32'h0222, 16'd5, 1'b0);
        exp_s(1, 32'h0111, 32'h0222, 16'd5, 1'b0);
        exp_c(1, 4'h3, 1'b0);
        pulse(4'b0010);
        drain("t3a_drain", 40);
        resp_status = 4'h4;
        set_ch(1, 32'h1111, 32'h1222, 16'd6, 1'b1);
        set_ch(3, 32'h3111, 32'h3222, 16'd7, 1'b0);
        exp_s(3, 32'h3111, 32'h3222, 16'd7, 1'b0);
        exp_c(3, 4'h4, 1'b0);
        exp_s(1, 32'h1111, 32'h1222, 16'd6, 1'b1);
        exp_c(1, 4'h4, 1'b0);
        pulse(4'b1010);
        drain("t3b_drain", 60);

        // Timeout: no done, then a late done must produce nothing.
        auto_done = 1'b0;
        set_ch(1, 32'h5000, 32'h6000, 16'd8, 1'b0);
        exp_s(1, 32'h5000, 32'h6000, 16'd8, 1'b0);
        exp_c(1, 4'hF, 1'b1);
        pulse(4'b0010);
        drain("t4_drain", 60);
        chk("t4_to_lat", last_cpl_cyc - last_start_cyc, TIMEOUT + 1);
        c0 = n_cpl;
        @(negedge clk);
        dma_done = 1'b1; dma_status = 4'h9;
        @(negedge clk);
        dma_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_late_done", n_cpl, c0);

        // Zero-length descriptor on ch0.
        auto_done = 1'b1;
        set_ch(0, 32'h7000, 32'h8000, 16'd0, 1'b1);
        exp_c(0, 4'h0, 1'b0);
        c0 = n_start;
        pulse(4'b0001);
        drain("t5_drain", 20);
        chk("t5_no_start", n_start, c0);
        chk("t5_cpl_lat", last_cpl_cyc - acc_cyc, 1);

        // Reset asserted during WAIT.
        auto_done = 1'b0;
        set_ch(2, 32'h9000, 32'h9100, 16'd4, 1'b1);
        exp_s(2, 32'h9000, 32'h9100, 16'd4, 1'b1);
        pulse(4'b0100);
        drain("t6_start", 20);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_src", dma_src_addr, 0);
        chk("t6_rst_ctrl", {dma_length, dma_channel, dma_burst, dma_start, cpl_valid,
                            cpl_channel, cpl_status, cpl_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = n_cpl;
        #1;
        chk("t6_ready", req_ready, 4'hF);
        repeat (20) @(negedge clk);
        chk("t6_no_cpl", n_cpl, c0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_chan_sched.md
Name: dma_chan_sched

Overview:
- Round-robin scheduler that shares one DMA engine among NUM_CH software/agent requesters.
- Each requester posts one descriptor: src, dst, length and burst.
- The block grants one descriptor at a time, drives the engine's src_addr/dst_addr/length/channel/burst/start signals, and waits for done.
- It then reports per-channel completion with the engine's status.
- Sits between channel request logic and the DMA engine's control interface.

Parameters:
- NUM_CH, 4, number of requesters, 1..8, limited by the 3-bit channel field.
- TIMEOUT, 1024, maximum cycles in WAIT before forced completion, must be ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  per-channel descriptor valid
- req_ready  out  NUM_CH  per-channel slot free
- req_src  in  NUM_CH*32  source addresses, channel i at [32i+:32]
- req_dst  in  NUM_CH*32  destination addresses
- req_len  in  NUM_CH*16  transfer lengths
- req_burst  in  NUM_CH  burst mode per channel
- dma_src_addr  out  32  to engine
- dma_dst_addr  out  32  to engine
- dma_length  out  16  to engine
- dma_channel  out  3  granted channel index
- dma_burst  out  1  to engine
- dma_start  out  1  one-cycle start pulse
- dma_done  in  1  engine completion pulse
- dma_status  in  4  engine status, valid with dma_done
- cpl_valid  out  1  one-cycle completion pulse
- cpl_channel  out  3  completed channel
- cpl_status  out  4  completion status
- cpl_timeout  out  1  completion caused by timeout

Behaviour:
- Reset (async on rst_n low, takes effect immediately):
  - All outputs 0; pending slots cleared; FSM = IDLE.
  - rr_ptr = 0; timeout counter = 0.
  - Reset mid-transfer abandons the transfer; no completion is reported.
- Slots:
  - req_ready[i] = ~pending[i].
  - On a clock edge with req_valid[i] & req_ready[i], the descriptor is latched into slot i and pending[i] is set.
  - Each channel may have exactly one outstanding descriptor.
- Arbitration: round-robin over pending slots, searching from rr_ptr upward with wrap at NUM_CH-1 → 0. Lowest index at or above rr_ptr wins.
- FSM:
  - IDLE: if any pending, select winner, register dma_* outputs from its slot, store grant index → ISSUE (or → CPL directly if length==0). Otherwise stay.
  - ISSUE: dma_start=1 for exactly this cycle; clear timeout counter → WAIT.
  - WAIT: dma_done sampled only in this state; done in the ISSUE cycle is ignored.
    - dma_done=1: capture dma_status → CPL.
    - Counter reaching TIMEOUT-1 without done: status=4'hF, set timeout flag → CPL.
  - CPL: cpl_valid=1 one cycle with cpl_channel, cpl_status, cpl_timeout. Clear pending[grant]; rr_ptr = grant+1 (wrap) → IDLE.
- Zero-length descriptor: dma_start is never asserted. Completes via CPL with status 4'h0, timeout 0.
- Latency: descriptor accepted at edge N (channel idle, no competitor):
  - dma_start high in cycle N+2.
  - cpl_valid high the cycle after the dma_done cycle.
  - req_ready[i] high again the cycle after cpl_valid.
- Output holding: dma_src_addr/dst_addr/length/channel/burst hold the last granted values until the next grant.
- Simultaneous events:
  - A new request on another channel during WAIT/CPL is latched normally.
  - A request on the granted channel is blocked until its slot clears.
  - A request arriving while in IDLE with other channels pending does not alter the current cycle's selection.
- dma_done outside WAIT is ignored. A late done after a timeout is discarded.

Test Plan:
- Reset: all outputs 0, req_ready all 1. Single request ch2 src=0x1000 dst=0x2000 len=64 burst=1 → dma_start 2 cycles after accept with those values and channel=2. Drive done with status=4'h1 3 cycles later → cpl_valid with ch2, status 1, timeout 0.
- All 4 channels request in the same cycle, done returned immediately each time → grant order 0,1,2,3. Re-request all → order 0,1,2,3 again (rr_ptr wrapped).
- Channels 1 and 3 pending, rr_ptr=2 → ch3 granted before ch1.
- No done driven, TIMEOUT=16 → cpl_valid 16 cycles after entering WAIT with status 4'hF and timeout=1. A done driven afterwards produces no completion.
- len=0 request on ch0 → no dma_start; cpl_valid with status 0.
- Assert rst_n low during WAIT → outputs 0 asynchronously; after release, req_ready all 1, no cpl_valid.
